// File: rtl/id_ex_stage_if.sv
// ID/EX stage bus: decoded ID fields and WB write port in, registered EX fields,
// hazard controls and performance counters out.
interface id_ex_stage_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  logic [XLEN-1:0]  idPc;
  logic [4:0]       idRs1;
  logic [4:0]       idRs2;
  logic             idUsesRs1;
  logic             idUsesRs2;
  logic [4:0]       idRd;
  logic [XLEN-1:0]  idRdata1;
  logic [XLEN-1:0]  idRdata2;
  logic [XLEN-1:0]  idImm;
  logic             idRegWrite;
  logic             idMemRead;
  logic             idMemWrite;
  logic             idMemToReg;
  logic             idAluSrc;
  logic [3:0]       idAluOp;
  logic             idBranch;
  logic             idValid;
  logic [4:0]       wbRd;
  logic             wbRegWrite;
  logic [XLEN-1:0]  wbData;
  logic             flush;

  logic             pcWrite;
  logic             ifidWrite;
  logic [XLEN-1:0]  exPc;
  logic [XLEN-1:0]  exRdata1;
  logic [XLEN-1:0]  exRdata2;
  logic [XLEN-1:0]  exImm;
  logic [4:0]       exRs1;
  logic [4:0]       exRs2;
  logic [4:0]       exRd;
  logic             exRegWrite;
  logic             exMemRead;
  logic             exMemWrite;
  logic             exMemToReg;
  logic             exAluSrc;
  logic             exBranch;
  logic             exValid;
  logic [3:0]       exAluOp;
  logic [CNT_W-1:0] stallCount;
  logic [CNT_W-1:0] flushCount;

  modport master (
    output idPc, idRs1, idRs2, idUsesRs1, idUsesRs2, idRd, idRdata1, idRdata2,
           idImm, idRegWrite, idMemRead, idMemWrite, idMemToReg, idAluSrc,
           idAluOp, idBranch, idValid, wbRd, wbRegWrite, wbData, flush,
    input  pcWrite, ifidWrite, exPc, exRdata1, exRdata2, exImm, exRs1, exRs2,
           exRd, exRegWrite, exMemRead, exMemWrite, exMemToReg, exAluSrc,
           exBranch, exValid, exAluOp, stallCount, flushCount
  );

  modport slave (
    input  idPc, idRs1, idRs2, idUsesRs1, idUsesRs2, idRd, idRdata1, idRdata2,
           idImm, idRegWrite, idMemRead, idMemWrite, idMemToReg, idAluSrc,
           idAluOp, idBranch, idValid, wbRd, wbRegWrite, wbData, flush,
    output pcWrite, ifidWrite, exPc, exRdata1, exRdata2, exImm, exRs1, exRs2,
           exRd, exRegWrite, exMemRead, exMemWrite, exMemToReg, exAluSrc,
           exBranch, exValid, exAluOp, stallCount, flushCount
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, WB-to-ID bypass on
// latch, branch-flush bubbles and saturating stall/flush counters.
module id_ex_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input logic          clk,
  input logic          reset,
  id_ex_stage_if.slave bus
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rdata1;
    logic [XLEN-1:0] rdata2;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [3:0]      alu_op;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            mem_to_reg;
    logic            alu_src;
    logic            branch;
    logic            valid;
  } ex_t;

  ex_t              ex_q;
  ex_t              ex_d;
  logic             load_use;
  logic             stall;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  // Hazard detection against the instruction currently held in EX; reset
  // forces the PC and IF/ID enables high.
  always_comb begin
    load_use = ex_q.valid && ex_q.mem_read && (ex_q.rd != 5'd0) && bus.idValid &&
               ((bus.idUsesRs1 && (bus.idRs1 == ex_q.rd)) ||
                (bus.idUsesRs2 && (bus.idRs2 == ex_q.rd)));
    stall    = load_use && !bus.flush && !reset;
  end

  assign bus.pcWrite   = !stall;
  assign bus.ifidWrite = !stall;

  // Next EX contents for a normal advance: WB bypass on operands (x0 never
  // bypassed), control flags zeroed when ID holds no real instruction.
  always_comb begin
    ex_d        = '0;
    ex_d.pc     = bus.idPc;
    ex_d.imm    = bus.idImm;
    ex_d.rs1    = bus.idRs1;
    ex_d.rs2    = bus.idRs2;
    ex_d.rd     = bus.idRd;
    ex_d.alu_op = bus.idAluOp;
    ex_d.valid  = bus.idValid;
    ex_d.rdata1 = (bus.wbRegWrite && (bus.wbRd != 5'd0) && (bus.wbRd == bus.idRs1)) ?
                  bus.wbData : bus.idRdata1;
    ex_d.rdata2 = (bus.wbRegWrite && (bus.wbRd != 5'd0) && (bus.wbRd == bus.idRs2)) ?
                  bus.wbData : bus.idRdata2;
    if (bus.idValid) begin
      ex_d.reg_write  = bus.idRegWrite;
      ex_d.mem_read   = bus.idMemRead;
      ex_d.mem_write  = bus.idMemWrite;
      ex_d.mem_to_reg = bus.idMemToReg;
      ex_d.alu_src    = bus.idAluSrc;
      ex_d.branch     = bus.idBranch;
    end
  end

  // Pipeline register: flush or stall loads an all-zero bubble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_q <= '0;
    end else if (bus.flush || stall) begin
      ex_q <= '0;
    end else begin
      ex_q <= ex_d;
    end
  end

  // Saturating bubble counters; flush takes priority so a cycle counts once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (bus.flush) begin
      if (flush_cnt != {CNT_W{1'b1}}) flush_cnt <= flush_cnt + 1'b1;
    end else if (stall) begin
      if (stall_cnt != {CNT_W{1'b1}}) stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign bus.exPc       = ex_q.pc;
  assign bus.exRdata1   = ex_q.rdata1;
  assign bus.exRdata2   = ex_q.rdata2;
  assign bus.exImm      = ex_q.imm;
  assign bus.exRs1      = ex_q.rs1;
  assign bus.exRs2      = ex_q.rs2;
  assign bus.exRd       = ex_q.rd;
  assign bus.exAluOp    = ex_q.alu_op;
  assign bus.exRegWrite = ex_q.reg_write;
  assign bus.exMemRead  = ex_q.mem_read;
  assign bus.exMemWrite = ex_q.mem_write;
  assign bus.exMemToReg = ex_q.mem_to_reg;
  assign bus.exAluSrc   = ex_q.alu_src;
  assign bus.exBranch   = ex_q.branch;
  assign bus.exValid    = ex_q.valid;
  assign bus.stallCount = stall_cnt;
  assign bus.flushCount = flush_cnt;

endmodule
